// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that turns host keystrokes into one-cycle command pulses; UART_CMD_PARITY_EN selects 8E1.
// Latency ~2+HALF_BIT+9*CLKS_PER_BIT+1 cycles from start edge to rx_byte_valid; no backpressure, pulses are not held.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [15:0] CPB = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HB  = 16'(HALF_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        sync1, rxs;
  logic        commit, ferr;
  logic [2:0]  dec;

`ifdef UART_CMD_PARITY_EN
  logic par_bad, par_bad_nxt, perr;
`else
  logic par_bad;
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    commit    = 1'b0;
    ferr      = 1'b0;
`ifdef UART_CMD_PARITY_EN
    par_bad_nxt = par_bad;
    perr        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          cnt_nxt   = 16'd1;
        end
      end
      START: begin
        if (cnt == HB) begin
          if (rxs) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = 16'd1;
            bit_nxt   = 3'd0;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == CPB) begin
          shreg_nxt = {rxs, shreg[7:1]};
          cnt_nxt   = 16'd1;
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
`ifdef UART_CMD_PARITY_EN
      PARITY: begin
        if (cnt == CPB) begin
          par_bad_nxt = rxs ^ (^shreg);
          cnt_nxt     = 16'd1;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt == CPB) begin
          if (!rxs) begin
            // A low stop bit may be a held break; wait for the line to recover.
            ferr      = 1'b1;
            state_nxt = BREAK;
`ifdef UART_CMD_PARITY_EN
            perr      = par_bad;
`endif
          end else if (par_bad) begin
            state_nxt = IDLE;
`ifdef UART_CMD_PARITY_EN
            perr      = 1'b1;
`endif
          end else begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      BREAK: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (shreg)
      "F", "f": dec = 3'd1;
      "P", "p": dec = 3'd2;
      "C", "c": dec = 3'd3;
      "S", "s": dec = 3'd4;
      "T", "t": dec = 3'd5;
      "?":      dec = 3'd6;
      default:  dec = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_code      <= '0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= commit;
      cmd_valid     <= commit && (dec != 3'd0);
      cmd_code      <= commit ? dec : 3'd0;
      frame_err     <= ferr;
      if (commit) rx_byte <= shreg;
    end
  end

`ifdef UART_CMD_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus random byte streams against a queue-based reference model.
module tb_uart_cmd_rx;
  localparam int CPB = 16;
`ifdef UART_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, cmd_valid, frame_err, parity_err, busy;
  logic [2:0] cmd_code;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] rxq[$];
  logic [2:0] cmdq[$];
  int ferr_n, perr_n, stray_n, busy_seen, rxv_cyc;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc++;

  // Event log sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rx_byte_valid) begin
      rxq.push_back(rx_byte);
      rxv_cyc = cyc;
    end
    if (cmd_valid) begin
      cmdq.push_back(cmd_code);
      if (!rx_byte_valid) stray_n++;
    end else if (cmd_code !== 3'd0) begin
      stray_n++;
    end
    if (frame_err) ferr_n++;
    if (parity_err) perr_n++;
    if (busy) busy_seen = 1;
  end

  function automatic logic [2:0] model_code(input logic [7:0] b);
    string keys;
    keys = "FPCST";
    for (int i = 0; i < 5; i++)
      if (b == keys[i] || b == (keys[i] | 8'h20)) return 3'(i + 1);
    return (b == "?") ? 3'd6 : 3'd0;
  endfunction

  task automatic clear_logs();
    rxq.delete();
    cmdq.delete();
    ferr_n = 0; perr_n = 0; stray_n = 0; busy_seen = 0; rxv_cyc = -1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level so a low stop can be extended into a break.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ pflip);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rx_byte, cmd_code} !== 11'd0) begin
      bad++; $display("FAIL reset_data got=%h/%0d exp=00/0", rx_byte, cmd_code);
    end
    total++;
    if ({rx_byte_valid, cmd_valid, frame_err, parity_err, busy} !== 5'd0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000",
                      {rx_byte_valid, cmd_valid, frame_err, parity_err, busy});
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_single();
    int c0, exp_lat;
    clear_logs();
    c0 = cyc;
    exp_lat = 2 + CPB / 2 + 9 * CPB + 1 + (PAR_EN ? CPB : 0);
    send_frame("f", 1'b1, 1'b0);
    idle(CPB);
    last_good = "f";
    total++;
    if (rxq.size() != 1 || rxq[0] !== 8'h66) begin
      bad++; $display("FAIL single_rx n=%0d got=%h exp=66", rxq.size(), rx_byte);
    end
    total++;
    if (cmdq.size() != 1 || cmdq[0] !== 3'd1) begin
      bad++; $display("FAIL single_cmd n=%0d exp one code 1", cmdq.size());
    end
    total++;
    if (stray_n != 0) begin
      bad++; $display("FAIL single_stray got=%0d exp=0", stray_n);
    end
    total++;
    if (busy_seen != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_busy seen=%0d now=%b exp=1/0", busy_seen, busy);
    end
    total++;
    if (rxv_cyc - c0 < exp_lat - 1 || rxv_cyc - c0 > exp_lat + 1) begin
      bad++; $display("FAIL single_latency got=%0d exp=%0d+-1", rxv_cyc - c0, exp_lat);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_frame("x", 1'b1, 1'b0);
    send_frame("?", 1'b1, 1'b0);
    idle(CPB);
    last_good = "?";
    total++;
    if (rxq.size() != 2 || rxq[0] !== 8'h78 || rxq[1] !== 8'h3F) begin
      bad++; $display("FAIL b2b_rx n=%0d last=%h exp=78,3f", rxq.size(), rx_byte);
    end
    total++;
    if (cmdq.size() != 1 || cmdq[0] !== 3'd6 || stray_n != 0) begin
      bad++; $display("FAIL b2b_cmd n=%0d stray=%0d exp one code 6", cmdq.size(), stray_n);
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    total++;
    if (rxq.size() != 0 || cmdq.size() != 0 || ferr_n != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL glitch_quiet rx=%0d cmd=%0d ferr=%0d busy=%b exp=0,0,0,0",
                      rxq.size(), cmdq.size(), ferr_n, busy);
    end
    send_frame("S", 1'b1, 1'b0);
    idle(CPB);
    last_good = "S";
    total++;
    if (cmdq.size() != 1 || cmdq[0] !== 3'd4) begin
      bad++; $display("FAIL glitch_next n=%0d exp one code 4", cmdq.size());
    end
  endtask

  task automatic test_frame_err();
    logic busy_held;
    clear_logs();
    send_frame(8'h50, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    busy_held = busy;
    idle(2 * CPB);
    total++;
    if (ferr_n != 1 || perr_n != 0) begin
      bad++; $display("FAIL ferr_count got=%0d/%0d exp=1/0", ferr_n, perr_n);
    end
    total++;
    if (rxq.size() != 0 || cmdq.size() != 0 || rx_byte !== last_good) begin
      bad++; $display("FAIL ferr_discard rx=%0d cmd=%0d byte=%h exp=0,0,%h",
                      rxq.size(), cmdq.size(), rx_byte, last_good);
    end
    total++;
    if (busy_held !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ferr_break busy held=%b after=%b exp=1/0", busy_held, busy);
    end
    clear_logs();
    send_frame("p", 1'b1, 1'b0);
    idle(CPB);
    last_good = "p";
    total++;
    if (cmdq.size() != 1 || cmdq[0] !== 3'd2 || ferr_n != 0) begin
      bad++; $display("FAIL ferr_next n=%0d ferr=%0d exp one code 2", cmdq.size(), ferr_n);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c = "c";
    clear_logs();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c[i]);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy got=%b exp=0", busy);
    end
    idle(12 * CPB);
    total++;
    if (rxq.size() != 0 || cmdq.size() != 0 || ferr_n != 0 || rx_byte !== 8'h00) begin
      bad++; $display("FAIL rstmid_quiet rx=%0d cmd=%0d ferr=%0d byte=%h exp=0,0,0,00",
                      rxq.size(), cmdq.size(), ferr_n, rx_byte);
    end
    send_frame("C", 1'b1, 1'b0);
    idle(CPB);
    last_good = "C";
    total++;
    if (cmdq.size() != 1 || cmdq[0] !== 3'd3) begin
      bad++; $display("FAIL rstmid_next n=%0d exp one code 3", cmdq.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_rx[$];
    logic [2:0] exp_cmd[$];
    string pool;
    logic [7:0] b;
    pool = "FfPpCcSsTt?xX0";
    clear_logs();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) b = pool[$urandom_range(0, pool.len() - 1)];
      else b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      idle($urandom_range(0, 20));
      exp_rx.push_back(b);
      if (model_code(b) != 3'd0) exp_cmd.push_back(model_code(b));
    end
    idle(CPB);
    last_good = exp_rx[$];
    total++;
    if (rxq.size() != exp_rx.size() || cmdq.size() != exp_cmd.size()) begin
      bad++; $display("FAIL rand_counts rx=%0d cmd=%0d exp=%0d,%0d",
                      rxq.size(), cmdq.size(), exp_rx.size(), exp_cmd.size());
    end else begin
      for (int i = 0; i < exp_rx.size(); i++) begin
        total++;
        if (rxq[i] !== exp_rx[i]) begin
          bad++; $display("FAIL rand_byte[%0d] got=%h exp=%h", i, rxq[i], exp_rx[i]);
        end
      end
      for (int i = 0; i < exp_cmd.size(); i++) begin
        total++;
        if (cmdq[i] !== exp_cmd[i]) begin
          bad++; $display("FAIL rand_cmd[%0d] got=%0d exp=%0d", i, cmdq[i], exp_cmd[i]);
        end
      end
    end
    total++;
    if (stray_n != 0 || ferr_n != 0 || perr_n != 0) begin
      bad++; $display("FAIL rand_stray stray=%0d ferr=%0d perr=%0d exp=0", stray_n, ferr_n, perr_n);
    end
  endtask

`ifdef UART_CMD_PARITY_EN
  task automatic test_parity();
    clear_logs();
    send_frame("T", 1'b1, 1'b0);
    idle(CPB);
    last_good = "T";
    total++;
    if (cmdq.size() != 1 || cmdq[0] !== 3'd5 || perr_n != 0) begin
      bad++; $display("FAIL par_good n=%0d perr=%0d exp one code 5, perr 0", cmdq.size(), perr_n);
    end
    clear_logs();
    send_frame("T", 1'b1, 1'b1);
    idle(CPB);
    total++;
    if (perr_n != 1 || rxq.size() != 0 || cmdq.size() != 0 || rx_byte !== last_good) begin
      bad++; $display("FAIL par_bad perr=%0d rx=%0d cmd=%0d byte=%h exp=1,0,0,%h",
                      perr_n, rxq.size(), cmdq.size(), rx_byte, last_good);
    end
    clear_logs();
    send_frame("T", 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    idle(2 * CPB);
    total++;
    if (perr_n != 1 || ferr_n != 1 || rxq.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL par_both perr=%0d ferr=%0d rx=%0d busy=%b exp=1,1,0,0",
                      perr_n, ferr_n, rxq.size(), busy);
    end
  endtask
`endif

  initial begin
    clear_logs();
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef UART_CMD_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART receiver plus ASCII command decoder.
- Terminal side of the pet's serial link: the pet transmits ASCII status art, and this block decodes ASCII keystrokes from the host into one-cycle action pulses for the stat engine.
- Sits between the board uart_rx pin and the hunger/happiness/hygiene/energy/social update logic.
- 8N1 framing, LSB first; optional even parity.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200).
- HALF_BIT, CLKS_PER_BIT/2, start-bit mid-sample offset; derived, not to be overridden.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- uart_rx  input  1  asynchronous serial line; idle high.
- rx_byte  output  8  last received byte; holds until the next good byte.
- rx_byte_valid  output  1  one-cycle pulse: rx_byte updated.
- cmd_valid  output  1  one-cycle pulse: recognised command on cmd_code.
- cmd_code  output  3  0 none, 1 feed, 2 play, 3 clean, 4 sleep, 5 talk, 6 status request.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 without the option.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- uart_rx passes through a 2-flop synchroniser; both flops reset to 1. Only the synchronised signal (rxs) is used.
- Reset values: rx_byte=0, cmd_code=0, all pulses 0, busy=0, FSM=IDLE, bit counter 0, cycle counter 0.
- Reset asserted mid-frame aborts the frame immediately. No pulse is emitted for the aborted frame.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, counter=1.
  - START: when counter==HALF_BIT, resample rxs. If rxs==1 (glitch) -> IDLE, no output. Else -> DATA, counter=1, bit=0.
  - DATA: when counter==CLKS_PER_BIT, shift rxs into MSB (LSB-first assembly), counter=1, bit+1. After bit 7 -> STOP, or PARITY when the option is enabled.
  - PARITY (optional): sample after a full bit period; compare with the XOR of the data bits (even parity).
  - STOP: sample after a full bit period.
    - rxs==1 and no parity error: commit the byte.
    - rxs==0: pulse frame_err and go to BREAK.
    - Otherwise (stop high, parity mismatch): go to IDLE.
  - BREAK: wait for rxs==1, then -> IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- Commit cycle: on the cycle after the stop sample, rx_byte<=data and rx_byte_valid=1.
- Decode, same cycle as the commit:
  - 'F'/'f'=1, 'P'/'p'=2, 'C'/'c'=3, 'S'/'s'=4, 'T'/'t'=5, '?'=6.
  - Any recognised code pulses cmd_valid with cmd_code set.
  - Any other byte: cmd_valid=0, cmd_code=0.
  - cmd_code returns to 0 on the cycle after the pulse.
- Errored frames (frame or parity) do not update rx_byte and do not pulse rx_byte_valid or cmd_valid.
- Latency: first start-bit low at the pin to rx_byte_valid is 2 (synchroniser) + HALF_BIT + 8*CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles, ±1. Add CLKS_PER_BIT with parity.
- Back-to-back frames: IDLE detects the next start edge on the cycle after STOP. There is no dead time beyond one cycle.
- Counters: the cycle counter is 16 bits and saturates nowhere. Its compare is by equality, so CLKS_PER_BIT ≥ 4 is required.

Optional Feature:
- Macro UART_CMD_PARITY_EN.
- Defined:
  - Frame is 8E1; the PARITY state is inserted.
  - Mismatch pulses parity_err one cycle after the stop sample; the byte is discarded.
  - A frame with both a parity mismatch and a low stop bit pulses frame_err and parity_err together, then goes to BREAK.
- Undefined:
  - No PARITY state; 8N1.
  - parity_err tied 0.

Test Plan (CLKS_PER_BIT=16 in simulation):
- Reset then send 'f' (0x66) 8N1 -> rx_byte=0x66, one-cycle rx_byte_valid and cmd_valid, cmd_code=1 on the same cycle; busy high during the frame, low afterwards.
- Send 'x' (0x78) then '?' (0x3F) back-to-back with no idle gap -> two rx_byte_valid pulses. First has cmd_valid=0; second has cmd_valid=1 with cmd_code=6.
- Hold uart_rx low 4 cycles then high (glitch) -> FSM returns to IDLE, no pulses; a following 'S' gives cmd_code=4.
- Send 0x50 with the stop bit forced low, hold low 40 cycles, release -> single frame_err pulse, rx_byte unchanged, no cmd_valid; a following 'p' gives cmd_code=2.
- Assert rst for 1 cycle mid-way through the data bits of 'c' -> no pulses, busy=0 next cycle; the next full 'C' frame gives cmd_code=3.
- With UART_CMD_PARITY_EN: send 'T' with the correct parity bit 1 -> cmd_code=5. Resend with parity bit 0 -> parity_err pulse, no rx_byte_valid.
